// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet tracker.
// Collects 3-byte mouse packets and turns them into an absolute pointer
// position clamped to the screen. It also produces text-cell coordinates,
// button states and a video register write.
// Defining PS2_MOUSE_WHEEL_EN switches to 4-byte packets and exposes the
// wheel delta on wheel_delta.
module ps2_mouse_tracker #(
  parameter int MAX_X          = 1279,
  parameter int MAX_Y          = 1023,
  parameter int CELL_W_LOG2    = 4,
  parameter int CELL_H         = 20,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_code_ready,
  input  logic [7:0]  scan_code_in,
  output logic        mouse_state_ready,
  output logic        packet_error,
  output logic        button_left,
  output logic        button_middle,
  output logic        button_right,
  output logic [10:0] x_screen,
  output logic [9:0]  y_screen,
  output logic [6:0]  x_text,
  output logic [5:0]  y_text,
  output logic [3:0]  wheel_delta,
  output logic [3:0]  register_index,
  output logic [22:0] register_value
);

  localparam logic [3:0]         VIDEO_MOUSE_POSITION = 4'd1;
  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic signed [12:0] MAX_X_S  = 13'(MAX_X);
  localparam logic signed [12:0] MAX_Y_S  = 13'(MAX_Y);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYTE2  = 3'd1,
    BYTE3  = 3'd2,
`ifdef PS2_MOUSE_WHEEL_EN
    BYTE4  = 3'd3,
`endif
    UPDATE = 3'd4,
    SEND   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Header byte without its always-one marker bit:
  // [6] Y ovf, [5] X ovf, [4] Y sign, [3] X sign, [2] middle, [1] right, [0] left
  logic [6:0]       hdr_q, hdr_d;
  logic [7:0]       bx_q, bx_d;
  logic [7:0]       by_q, by_d;
  logic             pend_q, pend_d;   // header for next packet already taken in UPDATE
  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [6:0]       xt_q, xt_d;
  logic [5:0]       yt_q, yt_d;
  logic             bl_q, bl_d, bm_q, bm_d, br_q, br_d;
  logic [3:0]       ridx_q, ridx_d;
  logic [22:0]      rval_q, rval_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic signed [12:0] dx_s, dy_s, xs_s, ys_s;
  logic [10:0]        x_new_s;
  logic [9:0]         y_new_s;
  logic               hdr_ok_s;

`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] z_q, z_d;
  logic [3:0] wheel_q, wheel_d;
`endif

  assign hdr_ok_s = scan_code_in[3];

  // Signed deltas and clamped new position, computed 13 bits wide so nothing wraps
  always_comb begin
    if (hdr_q[5]) begin
      dx_s = 13'sd0;
    end else begin
      dx_s = $signed({{5{hdr_q[3]}}, bx_q});
    end
    if (hdr_q[6]) begin
      dy_s = 13'sd0;
    end else begin
      dy_s = $signed({{5{hdr_q[4]}}, by_q});
    end
    xs_s = $signed({2'b00, x_q}) + dx_s;
    ys_s = $signed({3'b000, y_q}) - dy_s;
    if (xs_s < 13'sd0) begin
      x_new_s = 11'd0;
    end else if (xs_s > MAX_X_S) begin
      x_new_s = MAX_X_S[10:0];
    end else begin
      x_new_s = xs_s[10:0];
    end
    if (ys_s < 13'sd0) begin
      y_new_s = 10'd0;
    end else if (ys_s > MAX_Y_S) begin
      y_new_s = MAX_Y_S[9:0];
    end else begin
      y_new_s = ys_s[9:0];
    end
  end

  // Packet FSM next state plus next values of all registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    bx_d    = bx_q;
    by_d    = by_q;
    pend_d  = pend_q;
    x_d     = x_q;
    y_d     = y_q;
    xt_d    = xt_q;
    yt_d    = yt_q;
    bl_d    = bl_q;
    bm_d    = bm_q;
    br_d    = br_q;
    ridx_d  = ridx_q;
    rval_d  = rval_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
    z_d     = z_q;
    wheel_d = wheel_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (scan_code_ready && hdr_ok_s) begin
          hdr_d   = {scan_code_in[7:4], scan_code_in[2:0]};
          state_d = BYTE2;
        end else if (scan_code_ready) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE2: begin
        if (scan_code_ready) begin
          bx_d    = scan_code_in;
          cnt_d   = '0;
          state_d = BYTE3;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BYTE3: begin
        if (scan_code_ready) begin
          by_d  = scan_code_in;
          cnt_d = '0;
`ifdef PS2_MOUSE_WHEEL_EN
          state_d = BYTE4;
`else
          state_d = UPDATE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef PS2_MOUSE_WHEEL_EN
      BYTE4: begin
        if (scan_code_ready) begin
          z_d     = scan_code_in[3:0];
          cnt_d   = '0;
          state_d = UPDATE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      UPDATE: begin
        // Everything is committed here so it is valid together with the ready pulse
        x_d     = x_new_s;
        y_d     = y_new_s;
        xt_d    = 7'(x_new_s >> CELL_W_LOG2);
        yt_d    = 6'(int'(y_new_s) / CELL_H);
        bl_d    = hdr_q[0];
        br_d    = hdr_q[1];
        bm_d    = hdr_q[2];
        ridx_d  = VIDEO_MOUSE_POSITION;
        rval_d  = {2'b00, y_new_s, x_new_s};
        rdy_d   = 1'b1;
        state_d = SEND;
`ifdef PS2_MOUSE_WHEEL_EN
        wheel_d = z_q;
`endif
        // A byte arriving now is the next header; the old one is consumed this cycle
        if (scan_code_ready && hdr_ok_s) begin
          hdr_d  = {scan_code_in[7:4], scan_code_in[2:0]};
          pend_d = 1'b1;
        end else if (scan_code_ready) begin
          err_d = 1'b1;
        end else begin
          pend_d = 1'b0;
        end
      end
      SEND: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (pend_q && scan_code_ready) begin
          bx_d    = scan_code_in;
          state_d = BYTE3;
        end else if (pend_q) begin
          state_d = BYTE2;
        end else if (scan_code_ready && hdr_ok_s) begin
          hdr_d   = {scan_code_in[7:4], scan_code_in[2:0]};
          state_d = BYTE2;
        end else if (scan_code_ready) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State, captured bytes and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= 7'd0;
      bx_q    <= 8'd0;
      by_q    <= 8'd0;
      pend_q  <= 1'b0;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      xt_q    <= 7'd0;
      yt_q    <= 6'd0;
      bl_q    <= 1'b0;
      bm_q    <= 1'b0;
      br_q    <= 1'b0;
      ridx_q  <= 4'd0;
      rval_q  <= 23'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
      z_q     <= 4'd0;
      wheel_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xt_q    <= xt_d;
      yt_q    <= yt_d;
      bl_q    <= bl_d;
      bm_q    <= bm_d;
      br_q    <= br_d;
      ridx_q  <= ridx_d;
      rval_q  <= rval_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
`ifdef PS2_MOUSE_WHEEL_EN
      z_q     <= z_d;
      wheel_q <= wheel_d;
`endif
    end
  end

  assign mouse_state_ready = rdy_q;
  assign packet_error      = err_q;
  assign button_left       = bl_q;
  assign button_middle     = bm_q;
  assign button_right      = br_q;
  assign x_screen          = x_q;
  assign y_screen          = y_q;
  assign x_text            = xt_q;
  assign y_text            = yt_q;
  assign register_index    = ridx_q;
  assign register_value    = rval_q;
`ifdef PS2_MOUSE_WHEEL_EN
  assign wheel_delta       = wheel_q;
`else
  assign wheel_delta       = 4'd0;
`endif

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker with a scoreboard of expected updates.
module tb_ps2_mouse_tracker;

  localparam int TO = 40;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_code_ready;
  logic [7:0]  scan_code_in;
  logic        mouse_state_ready, packet_error;
  logic        button_left, button_middle, button_right;
  logic [10:0] x_screen;
  logic [9:0]  y_screen;
  logic [6:0]  x_text;
  logic [5:0]  y_text;
  logic [3:0]  wheel_delta, register_index;
  logic [22:0] register_value;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .scan_code_ready(scan_code_ready), .scan_code_in(scan_code_in),
    .mouse_state_ready(mouse_state_ready), .packet_error(packet_error),
    .button_left(button_left), .button_middle(button_middle), .button_right(button_right),
    .x_screen(x_screen), .y_screen(y_screen), .x_text(x_text), .y_text(y_text),
    .wheel_delta(wheel_delta), .register_index(register_index), .register_value(register_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int x, y, xt, yt;
    int l, m, r;
    int wheel;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int tick_no = 0, err_seen = 0, last_err_tick = -1, rdy_seen = 0;
  int xm = 0, ym = 0, last_rval = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: observe DUT at the falling edge, compare any update, then drive
  task automatic tick(input bit v, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    tick_no++;
    if (packet_error === 1'b1) begin
      err_seen++;
      last_err_tick = tick_no;
    end
    if (mouse_state_ready === 1'b1) begin
      rdy_seen++;
      chk("ready_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("latency", tick_no, e.due);
        chk("x_screen", x_screen, e.x);
        chk("y_screen", y_screen, e.y);
        chk("x_text", x_text, e.xt);
        chk("y_text", y_text, e.yt);
        chk("button_left", button_left, e.l);
        chk("button_middle", button_middle, e.m);
        chk("button_right", button_right, e.r);
        chk("wheel_delta", wheel_delta, e.wheel);
        chk("register_index", register_index, 32'd1);
        chk("register_value", register_value, e.y * 2048 + e.x);
        last_rval = e.y * 2048 + e.x;
      end
    end
    scan_code_ready = v;
    scan_code_in    = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  // Reference model of one decoded packet
  task automatic model_pkt(input logic [7:0] b1, b2, b3, b4, input int due);
    exp_t e;
    int dx, dy;
    dx = b1[6] ? 0 : (b1[4] ? int'(b2) - 256 : int'(b2));
    dy = b1[7] ? 0 : (b1[5] ? int'(b3) - 256 : int'(b3));
    xm = xm + dx;
    if (xm < 0) xm = 0;
    if (xm > 1279) xm = 1279;
    ym = ym - dy;
    if (ym < 0) ym = 0;
    if (ym > 1023) ym = 1023;
    e.due = due; e.x = xm; e.y = ym; e.xt = xm / 16; e.yt = ym / 20;
    e.l = int'(b1[0]); e.r = int'(b1[1]); e.m = int'(b1[2]);
    e.wheel = WHEEL ? int'(b4[3:0]) : 0;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] b1, b2, b3, b4, input int gap);
    tick(1'b1, b1); idle(gap);
    tick(1'b1, b2); idle(gap);
    tick(1'b1, b3);
    if (WHEEL) begin
      idle(gap);
      tick(1'b1, b4);
    end
    model_pkt(b1, b2, b3, b4, tick_no + 2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, mouse_state_ready, 0);
    chk({tag, "_error"}, packet_error, 0);
    chk({tag, "_buttons"}, {button_left, button_middle, button_right}, 0);
    chk({tag, "_x"}, x_screen, 0);
    chk({tag, "_y"}, y_screen, 0);
    chk({tag, "_text"}, {x_text, y_text}, 0);
    chk({tag, "_wheel"}, wheel_delta, 0);
    chk({tag, "_reg"}, {register_index, register_value}, 0);
  endtask

  initial begin
    int e0, r0, t0;
    scan_code_ready = 1'b0;
    scan_code_in    = 8'h00;
    reset           = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("por");
    reset = 1'b1;
    idle(2);

    // First packet from reset: x=16, y clamps at 0, left button
    send_pkt(8'h09, 8'h10, 8'h05, 8'h00, 0);
    idle(4);
    chk("first_ready_count", rdy_seen, 1);

    // Left-edge clamp, then walk right to the right-edge clamp
    send_pkt(8'h18, 8'hFA, 8'h00, 8'h00, 1); idle(3);
    send_pkt(8'h18, 8'hF0, 8'h00, 8'h00, 1); idle(3);
    for (int i = 0; i < 4; i++) begin
      send_pkt(8'h08, 8'hFF, 8'h00, 8'h00, 0); idle(3);
    end
    send_pkt(8'h08, 8'hFA, 8'h00, 8'h00, 0); idle(3);
    send_pkt(8'h08, 8'h20, 8'h00, 8'h00, 0); idle(3);

    // Overflow bits zero the deltas; button mapping
    send_pkt(8'hC8, 8'h40, 8'h40, 8'h00, 0); idle(3);
    send_pkt(8'h0F, 8'h00, 8'h00, 8'h00, 0); idle(3);
    send_pkt(8'h3E, 8'h80, 8'h90, 8'h00, 0); idle(3);

    // Next header during UPDATE, then next header during SEND
    send_pkt(8'h08, 8'h10, 8'h00, 8'h00, 0);
    send_pkt(8'h0C, 8'h10, 8'h00, 8'h00, 0);
    idle(1);
    send_pkt(8'h09, 8'h01, 8'h00, 8'h00, 0);
    idle(4);

    // Bad header byte in IDLE
    e0 = err_seen;
    tick(1'b1, 8'h00);
    t0 = tick_no;
    idle(3);
    chk("bad_hdr_err_count", err_seen - e0, 1);
    chk("bad_hdr_err_tick", last_err_tick, t0 + 1);
    send_pkt(8'h08, 8'h03, 8'h00, 8'h00, 0); idle(3);

    // Gap one cycle short of the timeout still completes the packet
    e0 = err_seen;
    send_pkt(8'h08, 8'h02, 8'h00, 8'h00, TO - 1); idle(3);
    chk("near_timeout_no_err", err_seen - e0, 0);

    // Timeout after two bytes
    e0 = err_seen;
    r0 = rdy_seen;
    tick(1'b1, 8'h08);
    tick(1'b1, 8'h05);
    t0 = tick_no;
    for (int i = 0; i < TO + 5; i++) begin
      if (err_seen == e0) tick(1'b0, 8'h00);
    end
    chk("timeout_err_count", err_seen - e0, 1);
    chk("timeout_err_tick", last_err_tick, t0 + TO + 1);
    chk("timeout_no_ready", rdy_seen - r0, 0);
    chk("timeout_x_kept", x_screen, xm);
    chk("timeout_y_kept", y_screen, ym);
    send_pkt(8'h18, 8'hFE, 8'h00, 8'h00, 0); idle(3);

    // Reset in the middle of a packet
    e0 = err_seen;
    r0 = rdy_seen;
    tick(1'b1, 8'h08);
    tick(1'b1, 8'h05);
    @(negedge clk);
    scan_code_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    xm = 0;
    ym = 0;
    idle(6);
    chk("midreset_no_err", err_seen - e0, 0);
    chk("midreset_no_ready", rdy_seen - r0, 0);

    // Wheel packet (3-byte packet without the wheel build), back to x=0, then dy=-20
    send_pkt(8'h08, 8'h01, 8'h01, 8'h0F, 0); idle(3);
    send_pkt(8'h18, 8'hFF, 8'h00, 8'h00, 0); idle(3);
    send_pkt(8'h28, 8'h00, 8'hEC, 8'h00, 0); idle(5);

    chk("scoreboard_empty", sb.size(), 0);
    chk("register_hold", register_value, last_rval);
    chk("y_text_final", y_text, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tracker.md
PS2_MOUSE_TRACKER -- requirements
Module: ps2_mouse_tracker

Interface
REQ-001 SHALL have parameter MAX_X, default 1279, rightmost x_screen value.
REQ-002 SHALL have parameter MAX_Y, default 1023, bottom y_screen value.
REQ-003 SHALL have parameter CELL_W_LOG2, default 4, log2 of text cell width in pixels.
REQ-004 SHALL have parameter CELL_H, default 20, text cell height in pixels.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, maximum clk cycles allowed between bytes of one packet.
REQ-006 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, asynchronous active-low reset), listed first.
REQ-007 SHALL have ports scan_code_ready (in, 1, byte strobe) and scan_code_in (in, 8, received byte).
REQ-008 SHALL have ports mouse_state_ready (out, 1, update pulse) and packet_error (out, 1, dropped-packet pulse).
REQ-009 SHALL have ports button_left, button_middle and button_right (out, 1 each, button states).
REQ-010 SHALL have ports x_screen (out, 11), y_screen (out, 10), x_text (out, 7) and y_text (out, 6), giving pointer position.
REQ-011 SHALL have port wheel_delta (out, 4, signed Z movement of the last packet).
REQ-012 SHALL have ports register_index (out, 4) and register_value (out, 23), forming the video register write.

Function
REQ-013 SHALL use states IDLE, BYTE2, BYTE3, BYTE4, UPDATE and SEND; BYTE4 exists only with the wheel feature enabled.
REQ-014 SHALL, in IDLE, accept a strobed byte as byte 1 only if bit 3 is 1 and then go to BYTE2; otherwise it SHALL drop the byte, pulse packet_error for 1 cycle and stay in IDLE.
REQ-015 SHALL capture byte 2 (X) in BYTE2, then byte 3 (Y) in BYTE3, then byte 4 in BYTE4 when present, and SHALL go to UPDATE after the last byte.
REQ-016 SHALL count cycles without a strobe in BYTE2, BYTE3 and BYTE4; on reaching TIMEOUT_CYCLES it SHALL drop the partial packet, pulse packet_error and return to IDLE.
REQ-017 SHALL form deltas as 9-bit signed values: dx = {byte1[4], byte2} and dy = {byte1[5], byte3}.
REQ-018 SHALL force the X delta to 0 when byte1[6] (X overflow) is set, and the Y delta to 0 when byte1[7] (Y overflow) is set.
REQ-019 SHALL, in UPDATE, set x_screen = clamp(x_screen + dx, 0, MAX_X).
REQ-020 SHALL, in UPDATE, set y_screen = clamp(y_screen - dy, 0, MAX_Y), so that PS/2 "up" decreases y_screen.
REQ-021 SHALL compute the clamp arithmetic at least 12 bits wide and signed, so that no wrap-around occurs.
REQ-022 SHALL, in UPDATE, load the button outputs from byte1 bits 0 (left), 1 (right) and 2 (middle).
REQ-023 SHALL, in SEND, set mouse_state_ready high for exactly 1 cycle and set x_text = x_screen >> CELL_W_LOG2 and y_text = y_screen / CELL_H.
REQ-024 SHALL, in SEND, set register_index = VIDEO_MOUSE_POSITION and register_value = {2'b0, y_screen, x_screen}; these SHALL hold until the next SEND.
REQ-025 SHALL have a latency of 2 cycles: the last byte is strobed in cycle N, and mouse_state_ready plus all updated outputs are valid in cycle N+2.
REQ-026 SHALL accept a strobe arriving during UPDATE or SEND as byte 1 of the next packet, applying the bit-3 check; such a byte SHALL not be lost.
REQ-027 SHALL keep mouse_state_ready and packet_error low in every cycle other than those defined above.

Reset
REQ-028 SHALL, while reset is low, asynchronously force state to IDLE, clear the timeout counter and captured bytes, and set every output to 0.
REQ-029 SHALL discard any partial packet when reset is asserted mid-packet, with no ready or error pulse after release.

Configuration
REQ-030 SHALL, with PS2_MOUSE_WHEEL_EN defined, use 4-byte packets and set wheel_delta from byte4[3:0] in UPDATE.
REQ-031 SHALL, without PS2_MOUSE_WHEEL_EN, use 3-byte packets, omit the BYTE4 logic and drive wheel_delta constantly 0.

Verification
REQ-032 SHALL cover: from reset, packet 0x09,0x10,0x05 -> 2 cycles later x_screen=16, y_screen=0 (clamped), button_left=1, x_text=1, one ready pulse.
REQ-033 SHALL cover: from x=10, packet 0x18,0xF0,0x00 (dx=-16) -> x_screen=0; from x=1270, packet 0x08,0x20,0x00 -> x_screen=1279.
REQ-034 SHALL cover: packet 0x28,0x00,0xEC (dy=-20) from y=0 -> y_screen=20, y_text=1, register_value={2'b0,10'd20,11'd0}.
REQ-035 SHALL cover: byte 0x00 in IDLE -> packet_error pulse, state IDLE; a following valid packet then decodes normally.
REQ-036 SHALL cover: 0x08,0x05 followed by a TIMEOUT_CYCLES gap -> packet_error pulse, positions unchanged, next 3 bytes decode as a new packet.
REQ-037 SHALL cover: with WHEEL_EN, packet 0x08,0x01,0x01,0x0F -> wheel_delta=-1, x=1, y clamped 0; also reset asserted mid-packet -> all outputs 0 and no pulse.
